// File: rtl/ip_payload_extract8_if.sv
// rtl/ip_payload_extract8_if.sv - payload byte stream bundle for ip_payload_extract8
// Ports (signals):
//   payload_data  8  forwarded IP payload byte
//   payload_valid 1  byte qualifier
//   payload_sop   1  first payload byte of a datagram
//   payload_eop   1  last payload byte of a datagram
//   payload_err   1  one-cycle abort of the packet being forwarded
// master drives the stream, slave observes it.
interface ip_payload_extract8_if;
    logic [7:0] payload_data;
    logic       payload_valid;
    logic       payload_sop;
    logic       payload_eop;
    logic       payload_err;

    modport master (
        output payload_data,
        output payload_valid,
        output payload_sop,
        output payload_eop,
        output payload_err
    );

    modport slave (
        input payload_data,
        input payload_valid,
        input payload_sop,
        input payload_eop,
        input payload_err
    );
endinterface

// File: rtl/ip_payload_extract8.sv
// rtl/ip_payload_extract8.sv - byte-serial IPv4 receive sequencer forwarding only the IP payload
// Ports:
//   clk, sync_reset                 clock, asynchronous active-high reset
//   data_in/data_in_valid           IP-layer byte stream (no backpressure)
//   frame_start/frame_end           byte 0 of datagram / last byte of Ethernet frame
//   dec_header_length/total_length/protocol/header_valid  fields from the parallel 12-byte header decoder
//   payload (master)                forwarded payload stream with sop/eop/err
//   protocol_out, src_ip, dst_ip, payload_length  latched header fields
//   pkt_done, hdr_err, csum_err, len_err          per-packet status pulse and status bits
module ip_payload_extract8 #(
    parameter int MAX_IHL = 15
) (
    input  logic                  clk,
    input  logic                  sync_reset,
    input  logic [7:0]            data_in,
    input  logic                  data_in_valid,
    input  logic                  frame_start,
    input  logic                  frame_end,
    input  logic [3:0]            dec_header_length,
    input  logic [15:0]           dec_total_length,
    input  logic [7:0]            dec_protocol,
    input  logic                  dec_header_valid,
    ip_payload_extract8_if.master payload,
    output logic [7:0]            protocol_out,
    output logic [31:0]           src_ip,
    output logic [31:0]           dst_ip,
    output logic [15:0]           payload_length,
    output logic                  pkt_done,
    output logic                  hdr_err,
    output logic                  csum_err,
    output logic                  len_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_CAPTURE,
        S_OPTIONS,
        S_PAYLOAD,
        S_DRAIN
    } state_t;

    localparam logic [4:0] MAX_IHL_W = 5'(MAX_IHL);

    state_t      state;
    logic [15:0] byte_cnt;      // index of the byte currently on data_in
    logic [16:0] acc;           // one's-complement accumulator, bit 16 is the pending carry
    logic [7:0]  hi_byte;       // even-index byte waiting for its odd partner
    logic [15:0] hdr_bytes;     // 4*IHL
    logic [15:0] tot_len;

    logic [7:0]  pd_data;
    logic        pd_valid;
    logic        pd_sop;
    logic        pd_eop;
    logic        pd_err;

    logic [15:0] cnt_inc;
    logic [16:0] acc_step;
    logic [15:0] csum_fold;
    logic [15:0] dec_hdr_bytes;
    logic        bad_hdr;
    logic        bad_len;
    logic        hdr_last;
    logic        pay_last;
    logic        byte_end;
    logic        short_frame;
    logic        csum_bad;
    logic        hdr_accept;

    assign payload.payload_data  = pd_data;
    assign payload.payload_valid = pd_valid;
    assign payload.payload_sop   = pd_sop;
    assign payload.payload_eop   = pd_eop;
    assign payload.payload_err   = pd_err;

    always_comb begin
        cnt_inc       = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
        // End-around carry: the previous carry is folded back in on the next add.
        acc_step      = {1'b0, acc[15:0]} + {16'd0, acc[16]} + {1'b0, hi_byte, data_in};
        csum_fold     = acc_step[15:0] + {15'd0, acc_step[16]};
        dec_hdr_bytes = {10'd0, dec_header_length, 2'b00};
        bad_hdr       = !dec_header_valid || (dec_header_length < 4'd5) ||
                        ({1'b0, dec_header_length} > MAX_IHL_W);
        bad_len       = dec_total_length < dec_hdr_bytes;
        hdr_last      = byte_cnt == (hdr_bytes - 16'd1);
        pay_last      = byte_cnt == (tot_len - 16'd1);
        byte_end      = data_in_valid && frame_end;
        short_frame   = frame_end && !pay_last;
        csum_bad      = csum_fold != 16'hFFFF;
        hdr_accept    = data_in_valid &&
                        ((state == S_HEADER) || (state == S_CAPTURE) || (state == S_OPTIONS));
    end

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            state          <= S_IDLE;
            byte_cnt       <= '0;
            acc            <= '0;
            hi_byte        <= '0;
            hdr_bytes      <= '0;
            tot_len        <= '0;
            pd_data        <= '0;
            pd_valid       <= 1'b0;
            pd_sop         <= 1'b0;
            pd_eop         <= 1'b0;
            pd_err         <= 1'b0;
            protocol_out   <= '0;
            src_ip         <= '0;
            dst_ip         <= '0;
            payload_length <= '0;
            pkt_done       <= 1'b0;
            hdr_err        <= 1'b0;
            csum_err       <= 1'b0;
            len_err        <= 1'b0;
        end else begin
            // Pulses and status bits only live for the single reporting cycle.
            pd_data  <= 8'h00;
            pd_valid <= 1'b0;
            pd_sop   <= 1'b0;
            pd_eop   <= 1'b0;
            pd_err   <= 1'b0;
            pkt_done <= 1'b0;
            hdr_err  <= 1'b0;
            csum_err <= 1'b0;
            len_err  <= 1'b0;

            if (data_in_valid && frame_start) begin
                // A packet still in flight is reported as truncated; DRAIN has already reported.
                if ((state == S_HEADER) || (state == S_CAPTURE) ||
                    (state == S_OPTIONS) || (state == S_PAYLOAD)) begin
                    pkt_done <= 1'b1;
                    len_err  <= 1'b1;
                end
                if (state == S_PAYLOAD) begin
                    pd_err <= 1'b1;
                end
                state    <= S_HEADER;
                byte_cnt <= 16'd1;
                acc      <= '0;
                hi_byte  <= data_in;
            end else begin
                if (data_in_valid && (state != S_IDLE)) begin
                    byte_cnt <= cnt_inc;
                end

                if (hdr_accept) begin
                    if (byte_cnt[0]) begin
                        acc <= acc_step;
                    end else begin
                        hi_byte <= data_in;
                    end
                    if ((byte_cnt >= 16'd12) && (byte_cnt <= 16'd15)) begin
                        src_ip <= {src_ip[23:0], data_in};
                    end
                    if ((byte_cnt >= 16'd16) && (byte_cnt <= 16'd19)) begin
                        dst_ip <= {dst_ip[23:0], data_in};
                    end
                end

                case (state)
                    S_IDLE: begin
                    end
                    S_HEADER: begin
                        if (data_in_valid) begin
                            if (frame_end) begin
                                pkt_done <= 1'b1;
                                len_err  <= 1'b1;
                                state    <= S_IDLE;
                            end else if (byte_cnt == 16'd11) begin
                                state <= S_CAPTURE;
                            end
                        end
                    end
                    S_CAPTURE: begin
                        // Decoder holds bytes 0..11 now; a byte arriving here is byte 12.
                        if (bad_hdr || bad_len) begin
                            pkt_done <= 1'b1;
                            hdr_err  <= bad_hdr;
                            len_err  <= bad_len || byte_end;
                            state    <= byte_end ? S_IDLE : S_DRAIN;
                        end else begin
                            hdr_bytes      <= dec_hdr_bytes;
                            tot_len        <= dec_total_length;
                            payload_length <= dec_total_length - dec_hdr_bytes;
                            protocol_out   <= dec_protocol;
                            if (byte_end) begin
                                pkt_done <= 1'b1;
                                len_err  <= 1'b1;
                                state    <= S_IDLE;
                            end else begin
                                state <= S_OPTIONS;
                            end
                        end
                    end
                    S_OPTIONS: begin
                        if (data_in_valid) begin
                            if (hdr_last) begin
                                if (csum_bad || short_frame || (tot_len == hdr_bytes)) begin
                                    pkt_done <= 1'b1;
                                    csum_err <= csum_bad;
                                    len_err  <= short_frame;
                                    state    <= frame_end ? S_IDLE : S_DRAIN;
                                end else begin
                                    state <= S_PAYLOAD;
                                end
                            end else if (frame_end) begin
                                pkt_done <= 1'b1;
                                len_err  <= 1'b1;
                                state    <= S_IDLE;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        if (data_in_valid) begin
                            pd_data  <= data_in;
                            pd_valid <= 1'b1;
                            pd_sop   <= byte_cnt == hdr_bytes;
                            if (pay_last) begin
                                pd_eop   <= 1'b1;
                                pkt_done <= 1'b1;
                                state    <= frame_end ? S_IDLE : S_DRAIN;
                            end else if (frame_end) begin
                                pd_eop   <= 1'b1;
                                pd_err   <= 1'b1;
                                pkt_done <= 1'b1;
                                len_err  <= 1'b1;
                                state    <= S_IDLE;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (byte_end) begin
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ip_payload_extract8.sv
// tb/tb_ip_payload_extract8.sv - scoreboard bench for ip_payload_extract8
module tb_ip_payload_extract8;

    logic        clk = 1'b0;
    logic        sync_reset;
    logic [7:0]  data_in;
    logic        data_in_valid;
    logic        frame_start;
    logic        frame_end;
    logic [3:0]  dec_header_length;
    logic [15:0] dec_total_length;
    logic [7:0]  dec_protocol;
    logic        dec_header_valid;
    logic [7:0]  protocol_out;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] payload_length;
    logic        pkt_done;
    logic        hdr_err;
    logic        csum_err;
    logic        len_err;

    ip_payload_extract8_if pl_if ();

    ip_payload_extract8 #(.MAX_IHL(15)) dut (
        .clk               (clk),
        .sync_reset        (sync_reset),
        .data_in           (data_in),
        .data_in_valid     (data_in_valid),
        .frame_start       (frame_start),
        .frame_end         (frame_end),
        .dec_header_length (dec_header_length),
        .dec_total_length  (dec_total_length),
        .dec_protocol      (dec_protocol),
        .dec_header_valid  (dec_header_valid),
        .payload           (pl_if),
        .protocol_out      (protocol_out),
        .src_ip            (src_ip),
        .dst_ip            (dst_ip),
        .payload_length    (payload_length),
        .pkt_done          (pkt_done),
        .hdr_err           (hdr_err),
        .csum_err          (csum_err),
        .len_err           (len_err)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] SRC   = 32'hC0A8010A;
    localparam logic [31:0] DST   = 32'hC0A80101;
    localparam logic [7:0]  PROTO = 8'h11;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int fs_cyc = 0;
    bit lat_arm = 1'b0;

    logic [11:0] pq [$];   // {valid, data, sop, eop, err}
    logic [2:0]  sq [$];   // {hdr_err, csum_err, len_err}
    logic [7:0]  fr [$];

    // Simple model of the upstream 12-byte header decoder.
    logic [7:0] dh [12];
    int         dcnt;
    always @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            dcnt <= 0;
        end else if (data_in_valid) begin
            if (frame_start) begin
                dh[0] <= data_in;
                dcnt  <= 1;
            end else if (dcnt < 12) begin
                dh[dcnt] <= data_in;
                dcnt     <= dcnt + 1;
            end
        end
    end
    assign dec_header_length = dh[0][3:0];
    assign dec_header_valid  = dh[0][7:4] == 4'd4;
    assign dec_total_length  = {dh[2], dh[3]};
    assign dec_protocol      = dh[9];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [11:0] obs;
        logic [2:0]  st;
        if (!sync_reset) begin
            if (data_in_valid && frame_start) fs_cyc = cyc;
            obs = {pl_if.payload_valid, pl_if.payload_data, pl_if.payload_sop,
                   pl_if.payload_eop, pl_if.payload_err};
            if (pl_if.payload_valid || pl_if.payload_err) begin
                if (pq.size() == 0) check("payload_unexpected", 32'(obs), 32'd0);
                else check("payload", 32'(obs), 32'(pq.pop_front()));
            end
            if (pkt_done) begin
                st = {hdr_err, csum_err, len_err};
                if (sq.size() == 0) check("status_unexpected", 32'(1'b1), 32'd0);
                else check("status", 32'(st), 32'(sq.pop_front()));
            end
            if (pl_if.payload_sop && lat_arm) check("sop_latency", 32'(cyc - fs_cyc), 32'd21);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic fs, input logic fe, input int gap);
        data_in       = b;
        frame_start   = fs;
        frame_end     = fe;
        data_in_valid = 1'b1;
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
        frame_start   = 1'b0;
        frame_end     = 1'b0;
        idle(gap);
    endtask

    task automatic build_frame(input int ihl, input int tot, input int flen,
                               input logic [3:0] ver, input bit flip);
        logic [7:0]  hb [60];
        int unsigned s;
        logic [15:0] c;
        fr.delete();
        for (int j = 0; j < 60; j++) hb[j] = 8'h00;
        hb[0] = {ver, 4'(ihl)};
        hb[2] = 8'(tot >> 8);
        hb[3] = 8'(tot);
        hb[4] = 8'h12;
        hb[5] = 8'h34;
        hb[8] = 8'h40;
        hb[9] = PROTO;
        for (int j = 0; j < 4; j++) begin
            hb[12 + j] = 8'(SRC >> (24 - 8 * j));
            hb[16 + j] = 8'(DST >> (24 - 8 * j));
        end
        for (int j = 20; j < 4 * ihl; j++) hb[j] = 8'h01;
        s = 0;
        for (int j = 0; j < 4 * ihl; j += 2) s += {16'd0, hb[j], hb[j + 1]};
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        c = ~s[15:0];
        hb[10] = c[15:8];
        hb[11] = c[7:0];
        if (flip) hb[10] = hb[10] ^ 8'h01;
        for (int i = 0; i < flen; i++) begin
            if (i < 4 * ihl)  fr.push_back(hb[i]);
            else if (i < tot) fr.push_back(8'(i * 7 + 3));
            else              fr.push_back(8'h00);
        end
    endtask

    task automatic run_frame(input int ihl, input int tot, input int flen, input logic [3:0] ver,
                             input bit flip, input int gap, input bit last_fe);
        bit bad_hdr;
        bit bad;
        bit fe;
        bad_hdr = ver != 4'd4;
        bad     = bad_hdr || flip;
        build_frame(ihl, tot, flen, ver, flip);
        if (bad_hdr)      sq.push_back(3'b100);
        else if (flip)    sq.push_back(3'b010);
        else if (last_fe) sq.push_back({2'b00, flen < tot});
        lat_arm = (gap == 0) && (ihl == 5) && !bad;
        for (int i = 0; i < flen; i++) begin
            fe = last_fe && (i == flen - 1);
            if (!bad && i >= 4 * ihl && i < tot)
                pq.push_back({1'b1, fr[i], i == 4 * ihl, (i == tot - 1) || fe, fe && (i < tot - 1)});
            drive_byte(fr[i], i == 0, fe, (i == flen - 1) ? 0 : gap);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        sync_reset    = 1'b1;
        data_in       = 8'h00;
        data_in_valid = 1'b0;
        frame_start   = 1'b0;
        frame_end     = 1'b0;
        idle(3);
        check("rst_payload", 32'({pl_if.payload_valid, pl_if.payload_data, pl_if.payload_sop,
                                  pl_if.payload_eop, pl_if.payload_err}), 32'd0);
        check("rst_status", 32'({pkt_done, hdr_err, csum_err, len_err}), 32'd0);
        check("rst_src", src_ip, 32'd0);
        check("rst_len_proto", {payload_length, 8'h00, protocol_out}, 32'd0);
        sync_reset = 1'b0;
        idle(2);

        // clean back-to-back packet
        run_frame(5, 28, 28, 4'd4, 1'b0, 0, 1'b1);
        idle(4);
        check("clean_src", src_ip, SRC);
        check("clean_dst", dst_ip, DST);
        check("clean_plen", 32'(payload_length), 32'd8);
        check("clean_proto", 32'(protocol_out), 32'(PROTO));

        // Ethernet padding
        run_frame(5, 28, 46, 4'd4, 1'b0, 0, 1'b1);
        idle(4);

        // IP options
        run_frame(6, 30, 30, 4'd4, 1'b0, 0, 1'b1);
        idle(4);
        check("opt_plen", 32'(payload_length), 32'd6);
        check("opt_dst", dst_ip, DST);

        // bad checksum, then version 6
        run_frame(5, 28, 46, 4'd4, 1'b1, 0, 1'b1);
        idle(4);
        run_frame(5, 28, 28, 4'd6, 1'b0, 0, 1'b1);
        idle(4);

        // truncated frame
        run_frame(5, 100, 40, 4'd4, 1'b0, 0, 1'b1);
        idle(4);
        check("trunc_plen", 32'(payload_length), 32'd80);

        // valid toggling every other cycle
        run_frame(5, 28, 28, 4'd4, 1'b0, 1, 1'b1);
        idle(4);
        check("gap_src", src_ip, SRC);

        // restart mid-payload
        run_frame(5, 28, 24, 4'd4, 1'b0, 0, 1'b0);
        pq.push_back({1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        sq.push_back(3'b001);
        run_frame(5, 28, 28, 4'd4, 1'b0, 0, 1'b1);
        idle(4);
        check("restart_plen", 32'(payload_length), 32'd8);

        // asynchronous reset mid-payload
        run_frame(5, 28, 25, 4'd4, 1'b0, 0, 1'b0);
        #2;
        sync_reset = 1'b1;
        #1;
        check("arst_payload", 32'({pl_if.payload_valid, pl_if.payload_data, pl_if.payload_sop,
                                   pl_if.payload_eop, pl_if.payload_err}), 32'd0);
        check("arst_src", src_ip, 32'd0);
        check("arst_dst", dst_ip, 32'd0);
        check("arst_len_proto", {payload_length, 8'h00, protocol_out}, 32'd0);
        pq.delete();
        sq.delete();
        idle(2);
        sync_reset = 1'b0;
        idle(2);
        run_frame(5, 28, 28, 4'd4, 1'b0, 0, 1'b1);
        idle(4);
        check("post_rst_src", src_ip, SRC);

        idle(6);
        check("payload_queue_empty", 32'(pq.size()), 32'd0);
        check("status_queue_empty", 32'(sq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
